// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the pipelined MIPS datapath.
//
// This stage owns the program counter and the instruction-memory request.
// It sends the fetched instruction, its PC and its link address (PC+4) to IF/ID.
// It also redirects on taken branches (from MEM) and on jumps (from ID).
// It holds on hazard stalls and stops fetching for good on HALT.
//
// Ports:
//   CLK, RST            clock; asynchronous active-high reset
//   ihit, imemload      instruction-memory response for the current imemaddr
//   imemREN, imemaddr   instruction-memory request
//   stall               hazard freeze (hold PC)
//   brnch_take/addr     taken branch from MEM (older, so it wins)
//   jump_take/addr      J/JAL/JR from ID
//   halt                HALT retired; stop fetching until reset
//   ifinstr, ifpc       instruction and its PC for IF/ID (ifinstr is a NOP when not valid)
//   ifJALjump_addr      PC+4 (JAL link value)
//   ifvalid             ifinstr is a real, non-squashed instruction
//   ifflush             redirect accepted; IF/ID must load a bubble
module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        stall,
    input  logic        brnch_take,
    input  logic [31:0] brnch_addr,
    input  logic        jump_take,
    input  logic [31:0] jump_addr,
    input  logic        halt,
    output logic [31:0] ifinstr,
    output logic [31:0] ifJALjump_addr,
    output logic [31:0] ifpc,
    output logic        ifvalid,
    output logic        ifflush
);

    typedef enum logic [1:0] {
        StFetch     = 2'd0,
        StRedirWait = 2'd1,
        StHalted    = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_q, pend_d;

    logic        redir;
    logic [31:0] target_raw;
    logic [31:0] target;
    logic [31:0] pc_plus4;

    // The branch is older than the jump, so the branch wins.
    assign redir      = brnch_take | jump_take;
    assign target_raw = brnch_take ? brnch_addr : jump_addr;
    assign target     = {target_raw[31:2], 2'b00};
    assign pc_plus4   = pc_q + 32'd4;

    // Datapath outputs
    assign imemaddr       = pc_q;
    assign ifpc           = pc_q;
    assign ifJALjump_addr = pc_plus4;
    assign ifinstr        = ifvalid ? imemload : 32'h0000_0000;

    always_comb begin
        imemREN = 1'b1;
        ifvalid = 1'b0;
        ifflush = 1'b0;
        pc_d    = pc_q;
        pend_d  = pend_q;
        state_d = state_q;

        unique case (state_q)
            StFetch: begin
                if (halt) begin
                    state_d = StHalted;
                end else if (redir) begin
                    ifflush = 1'b1;
                    if (ihit) begin
                        pc_d = target;
                    end else begin
                        // Keep the outstanding request stable and remember the target.
                        pend_d  = target;
                        state_d = StRedirWait;
                    end
                end else if (!stall && ihit) begin
                    pc_d    = pc_plus4;
                    ifvalid = 1'b1;
                end
            end
            StRedirWait: begin
                if (halt) begin
                    state_d = StHalted;
                end else begin
                    if (redir) begin
                        ifflush = 1'b1;
                        pend_d  = target;
                    end
                    if (ihit) begin
                        // The old request has completed and is discarded. Jump to the newest target.
                        pc_d    = redir ? target : pend_q;
                        state_d = StFetch;
                    end
                end
            end
            StHalted: begin
                imemREN = 1'b0;
            end
            default: begin
                state_d = StFetch;
            end
        endcase

        // Reset is asynchronous. While it is held, the stage must not present anything.
        if (RST) begin
            ifvalid = 1'b0;
            ifflush = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StFetch;
            pc_q    <= PC_INIT;
            pend_q  <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
        end
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined MIPS datapath. Owns the program counter and the instruction-memory request, and delivers the fetched instruction and its link address (PC+4) into the IF/ID pipeline register. It also redirects on taken branches from MEM and jumps from ID, holds on hazard stalls, and stops fetching on HALT.

## Interface
Parameters:
- PC_INIT, 32'h0000_0000, PC value loaded on reset.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- ihit  in  1  instruction memory has returned imemload for the current imemaddr.
- imemload  in  32  instruction word from instruction memory.
- imemREN  out  1  instruction-memory read enable.
- imemaddr  out  32  instruction-memory address.
- stall  in  1  hazard unit freeze: hold the PC; IF/ID holds its contents.
- brnch_take  in  1  taken branch resolved in MEM.
- brnch_addr  in  32  branch target.
- jump_take  in  1  J/JAL/JR resolved in ID.
- jump_addr  in  32  jump target.
- halt  in  1  HALT retired; stop fetching permanently.
- ifinstr  out  32  instruction to IF/ID; 32'h0 (NOP) when ifvalid=0.
- ifJALjump_addr  out  32  PC+4 of the fetched instruction (JAL link value).
- ifpc  out  32  PC of the fetched instruction.
- ifvalid  out  1  ifinstr is a real, non-squashed instruction this cycle.
- ifflush  out  1  redirect accepted this cycle; IF/ID must load a bubble.

## Operation
- Registers: PC[31:0]; pend_addr[31:0] (captured redirect target); state ∈ {FETCH, REDIR_WAIT, HALTED}.
- Redirect request: redir = brnch_take | jump_take. target = brnch_addr if brnch_take, else jump_addr. The branch wins because it is older. target[1:0] is forced to 2'b00.
- FETCH:
  - imemREN=1, imemaddr=PC.
  - halt → HALTED. This has priority over everything else.
  - redir & ihit: PC ← target; ifvalid=0; ifflush=1; stay in FETCH.
  - redir & !ihit: pend_addr ← target; → REDIR_WAIT; ifflush=1. imemaddr stays at PC because the cache request must remain stable.
  - !redir & stall: PC held; ifvalid=0.
  - !redir & !stall & ihit: PC ← PC+4; ifvalid=1.
  - !ihit: PC held; ifvalid=0.
  - Redirect beats stall.
- REDIR_WAIT:
  - imemREN=1, imemaddr=PC (the outstanding old request).
  - ifvalid=0 always.
  - A new redir here overwrites pend_addr using the same priority rule; ifflush=1.
  - On ihit: PC ← pend_addr (or the new target, if redir is asserted in the same cycle); → FETCH.
  - halt → HALTED.
- HALTED:
  - imemREN=0; imemaddr=PC (frozen); ifvalid=0; ifflush=0.
  - Exit only by reset.
- Datapath outputs:
  - ifinstr = ifvalid ? imemload : 32'h0.
  - ifpc = PC.
  - ifJALjump_addr = PC+4.
- Arithmetic: PC+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000. PC[1:0] is always 00.

## Timing
- Reset (asynchronous; applies immediately and while RST is held): PC=PC_INIT, pend_addr=0, state=FETCH. Outputs under reset: imemREN=1, imemaddr=PC_INIT, ifvalid=0, ifinstr=0, ifflush=0, ifpc=PC_INIT, ifJALjump_addr=PC_INIT+4.
- While RST=1, ifvalid is forced to 0 regardless of ihit.
- ifvalid, ifinstr and ifflush are combinational from the current state and inputs. PC, pend_addr and state update on the CLK edge.
- Zero-wait memory (ihit tied to 1) sustains 1 instruction/cycle.
- Taken redirect penalty:
  - With ihit: the target is fetched on the very next cycle.
  - Without ihit: the target is fetched on the cycle after the old request completes.
- Reset asserted mid-REDIR_WAIT discards pend_addr. Fetch resumes at PC_INIT.
- Simultaneous cases:
  - halt & redir → HALTED.
  - brnch_take & jump_take → brnch_addr is used.
  - stall & redir → redirect is taken.

## Test plan
- Reset with PC_INIT=0, ihit=1, imemload=i<n>: after release, imemaddr steps 0,4,8,C. ifvalid=1 each cycle. ifJALjump_addr = imemaddr+4.
- stall=1 for 3 cycles at PC=8: imemaddr stays 8 and ifvalid=0. On release, the next cycle fetches 8 and then C.
- brnch_take=1, brnch_addr=32'h40 with jump_take=1, jump_addr=32'h80 in the same cycle, ihit=1: ifflush=1 and ifvalid=0; the next imemaddr=40.
- jump_take=1 with target 32'h100 while ihit=0 at PC=10: → REDIR_WAIT. imemaddr stays 10 until ihit (after 4 cycles), with no valid output meanwhile. Then imemaddr=100.
- PC=32'hFFFF_FFFC with ihit: the next imemaddr is 0.
- halt=1 at PC=20: next cycle imemREN=0. The PC stays 20 despite ihit, stall or redir pulses until RST; after RST, imemaddr=PC_INIT.
